// File: rtl/full_subtractor.sv
// Registered WIDTH-bit ripple-borrow full subtractor: {x,y} <= a - b - borrow.
// Outputs are registered only, so feeding x back into borrow forms no combinational loop.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow,
    output logic [WIDTH-1:0] y,
    output logic             x
);

    logic [WIDTH-1:0] diff;
    logic             bout;

    always_comb begin
        logic bin;
        // NOTE: every variable gets a default first, so no path can infer a latch.
        diff = '0;
        bin  = borrow;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ bin;
            bin     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bin);
        end
        bout = bin;
    end

    // NOTE: registers take non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
            x <= 1'b0;
        end else if (en) begin
            y <= diff;
            x <= bout;
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed checks of full_subtractor: a 1-bit cell (also run with x fed back
// into borrow) and an 8-bit instance for the multi-bit boundaries.
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;

    logic       a1, b1, bor_drv, fb;
    logic       borrow1;
    logic       y1, x1;

    logic [7:0] a8, b8;
    logic       bor8;
    logic [7:0] y8;
    logic       x8;

    int total = 0;
    int bad   = 0;

    assign borrow1 = fb ? x1 : bor_drv;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .a(a1), .b(b1), .borrow(borrow1),
        .y(y1), .x(x1)
    );

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en),
        .a(a8), .b(b8), .borrow(bor8),
        .y(y8), .x(x8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic a, input logic b, input logic bor);
        a1      = a;
        b1      = b;
        bor_drv = bor;
    endtask

    // {a,b,borrow} sweep 000..111 with hand-computed {y,x}
    logic [7:0] sweep_y = 8'b1001_0110;  // bit k = y for combo k
    logic [7:0] sweep_x = 8'b1000_1110;

    // Feedback chain vectors and expected results (borrow = previous x)
    logic [1:0] fb_ab [6] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00};
    logic       fb_y  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       fb_x  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        fb  = 1'b0;
        drive1(1'b0, 1'b0, 1'b0);
        a8 = 8'h00; b8 = 8'h00; bor8 = 1'b0;

        #1;
        check("rst_y1", {7'd0, y1}, 8'd0);
        check("rst_x1", {7'd0, x1}, 8'd0);
        check("rst_y8", y8, 8'h00);
        check("rst_x8", {7'd0, x8}, 8'd0);

        step();
        rst = 1'b0;

        // Basic cases
        drive1(1'b1, 1'b1, 1'b0);
        step();
        check("a1b1_y", {7'd0, y1}, 8'd0);
        check("a1b1_x", {7'd0, x1}, 8'd0);
        drive1(1'b0, 1'b1, 1'b0);
        step();
        check("a0b1_y", {7'd0, y1}, 8'd1);
        check("a0b1_x", {7'd0, x1}, 8'd1);

        // Asynchronous reset pulse mid-cycle with y=1, x=1
        #3 rst = 1'b1;
        #1;
        check("async_rst_y", {7'd0, y1}, 8'd0);
        check("async_rst_x", {7'd0, x1}, 8'd0);
        step();
        check("rst_hold_edge_y", {7'd0, y1}, 8'd0);
        check("rst_hold_edge_x", {7'd0, x1}, 8'd0);
        #3 rst = 1'b0;
        #1;
        check("rst_low_pre_edge_y", {7'd0, y1}, 8'd0);
        check("rst_low_pre_edge_x", {7'd0, x1}, 8'd0);
        step();
        check("first_capture_y", {7'd0, y1}, 8'd1);
        check("first_capture_x", {7'd0, x1}, 8'd1);

        // Exhaustive 1-bit sweep
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            drive1(v[2], v[1], v[0]);
            step();
            check($sformatf("sweep%0d_y", k), {7'd0, y1}, {7'd0, sweep_y[k]});
            check($sformatf("sweep%0d_x", k), {7'd0, x1}, {7'd0, sweep_x[k]});
        end

        // Bit-serial feedback chain starting from reset
        rst = 1'b1;
        #1 rst = 1'b0;
        fb = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive1(fb_ab[k][1], fb_ab[k][0], 1'b0);
            step();
            check($sformatf("chain%0d_y", k), {7'd0, y1}, {7'd0, fb_y[k]});
            check($sformatf("chain%0d_x", k), {7'd0, x1}, {7'd0, fb_x[k]});
        end
        fb = 1'b0;

        // Enable hold
        drive1(1'b0, 1'b1, 1'b0);
        step();
        check("pre_hold_y", {7'd0, y1}, 8'd1);
        check("pre_hold_x", {7'd0, x1}, 8'd1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       drive1(1'b1, 1'b1, 1'b0);
                1:       drive1(1'b1, 1'b0, 1'b0);
                default: drive1(1'b0, 1'b0, 1'b0);
            endcase
            step();
            check($sformatf("hold%0d_y", k), {7'd0, y1}, 8'd1);
            check($sformatf("hold%0d_x", k), {7'd0, x1}, 8'd1);
        end
        en = 1'b1;
        drive1(1'b1, 1'b0, 1'b0);
        step();
        check("reenable_y", {7'd0, y1}, 8'd1);
        check("reenable_x", {7'd0, x1}, 8'd0);

        // 8-bit boundaries
        a8 = 8'h00; b8 = 8'h01; bor8 = 1'b0;
        step();
        check("w8_00m01_y", y8, 8'hFF);
        check("w8_00m01_x", {7'd0, x8}, 8'd1);
        a8 = 8'h5A; b8 = 8'h5A; bor8 = 1'b1;
        step();
        check("w8_5a_bor_y", y8, 8'hFF);
        check("w8_5a_bor_x", {7'd0, x8}, 8'd1);
        a8 = 8'h80; b8 = 8'h7F; bor8 = 1'b0;
        step();
        check("w8_80m7f_y", y8, 8'h01);
        check("w8_80m7f_x", {7'd0, x8}, 8'd0);
        a8 = 8'h3C; b8 = 8'h3C; bor8 = 1'b0;
        step();
        check("w8_eq_y", y8, 8'h00);
        check("w8_eq_x", {7'd0, x8}, 8'd0);
        a8 = 8'h00; b8 = 8'h00; bor8 = 1'b1;
        step();
        check("w8_wrap_y", y8, 8'hFF);
        check("w8_wrap_x", {7'd0, x8}, 8'd1);
        a8 = 8'hFF; b8 = 8'h00; bor8 = 1'b0;
        step();
        check("w8_ones_y", y8, 8'hFF);
        check("w8_ones_x", {7'd0, x8}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
